// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg
//   Shared definitions for the MEM-stage data-RAM controller: access size
//   codes, FSM state encoding, default widths and the alignment rule.
//   No ports.
package ram_access_ctrl_pkg;

   localparam int AWIDTH_DEF = 12;  // RAM word-address width
   localparam int XLEN_DEF   = 64;  // core data width
   localparam int RAM_W      = 32;  // RAM data width, 4 byte lanes

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_D = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACC0 = 3'd1,
      ST_ACC1 = 3'd2,
      ST_WAIT = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   // Natural alignment: an access of 2^size bytes must start on a
   // 2^size byte boundary.
   function automatic logic misaligned(size_e size, logic [2:0] a);
      logic m;
      case (size)
         SIZE_B:  m = 1'b0;
         SIZE_H:  m = a[0];
         SIZE_W:  m = |a[1:0];
         default: m = |a;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if
//   Request/response bundle between the MEM-stage pipeline (master) and
//   the RAM access controller (slave).
//   req_*  : one load/store request, accepted on req_valid & req_ready
//   resp_* : one-cycle completion pulse, no backpressure
//   busy   : controller not idle
interface ram_access_ctrl_if
   import ram_access_ctrl_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int XLEN   = XLEN_DEF
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   size_e             req_size;
   logic              req_unsigned;
   logic [AWIDTH+1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [XLEN-1:0]   resp_rdata;
   logic              busy;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata, busy
   );
endinterface

// File: rtl/ram_access_ctrl_load_align.sv
// load_align
//   Combinational load alignment: selects the addressed lane of the low
//   RAM word and sign/zero-extends B/H/W to XLEN; D passes {hi,lo} through.
//   size : access size code
//   uns  : zero-extend (ignored for D)
//   k    : byte offset within the word
//   dw   : {hi word, lo word}; hi only meaningful for D
//   data : extended result
module load_align
   import ram_access_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  size_e              size,
   input  logic               uns,
   input  logic [1:0]         k,
   input  logic [2*RAM_W-1:0] dw,
   output logic [XLEN-1:0]    data
);
   logic [RAM_W-1:0] lane;

   // Shift the addressed byte down to lane 0.
   assign lane = dw[RAM_W-1:0] >> {k, 3'b000};

   always_comb begin
      data = '0;
      case (size)
         SIZE_B:  data = {{(XLEN-8){lane[7] & ~uns}}, lane[7:0]};
         SIZE_H:  data = {{(XLEN-16){lane[15] & ~uns}}, lane[15:0]};
         SIZE_W:  data = {{(XLEN-32){lane[31] & ~uns}}, lane[31:0]};
         default: data = dw[XLEN-1:0];
      endcase
   end
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Sequences the 32-bit byte-write-enable data RAM for RV64I loads and
//   stores. Doubleword accesses take two RAM cycles (word w, then w+1 with
//   wrap). Misaligned requests return resp_err without touching the RAM.
//   clk, rst_n : clock, async active-low reset (aborts any access)
//   bus        : request/response bundle (slave side)
//   ram_addr   : RAM word address
//   ram_we     : per-lane write enable
//   ram_di     : RAM write data
//   ram_do     : RAM read data, valid one cycle after ram_addr
module ram_access_ctrl
   import ram_access_ctrl_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int XLEN   = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_access_ctrl_if.slave  bus,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [3:0]        ram_we,
   output logic [RAM_W-1:0]  ram_di,
   input  logic [RAM_W-1:0]  ram_do
);
   state_e           state;
   logic             we_q;
   size_e            size_q;
   logic             uns_q;
   logic [1:0]       k_q;
   logic [RAM_W-1:0] whi_q;   // store hi word for the second D cycle
   logic [RAM_W-1:0] lo_q;    // load lo word captured during D
   logic [3:0]       st_be;
   logic [RAM_W-1:0] st_di;
   logic [XLEN-1:0]  ld_data;
   logic [2*RAM_W-1:0] ld_dw;

   assign bus.req_ready = (state == ST_IDLE);
   assign bus.busy      = (state != ST_IDLE);

   // Store steering from the request as presented: data is replicated
   // across lanes so only the byte enables depend on the offset.
   always_comb begin
      st_be = 4'hF;
      st_di = bus.req_wdata[RAM_W-1:0];
      case (bus.req_size)
         SIZE_B: begin
            st_be = 4'b0001 << bus.req_addr[1:0];
            st_di = {4{bus.req_wdata[7:0]}};
         end
         SIZE_H: begin
            st_be = 4'b0011 << bus.req_addr[1:0];
            st_di = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // In WAIT, ram_do holds the only word (B/H/W) or the hi word (D).
   assign ld_dw = (size_q == SIZE_D) ? {ram_do, lo_q} : {{RAM_W{1'b0}}, ram_do};

   load_align #(.XLEN(XLEN)) u_align (
      .size (size_q),
      .uns  (uns_q),
      .k    (k_q),
      .dw   (ld_dw),
      .data (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         we_q           <= 1'b0;
         size_q         <= SIZE_B;
         uns_q          <= 1'b0;
         k_q            <= '0;
         whi_q          <= '0;
         lo_q           <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= '0;
         ram_addr       <= '0;
         ram_we         <= '0;
         ram_di         <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         ram_we         <= '0;
         case (state)
            ST_IDLE: if (bus.req_valid) begin
               we_q   <= bus.req_we;
               size_q <= bus.req_size;
               uns_q  <= bus.req_unsigned;
               k_q    <= bus.req_addr[1:0];
               whi_q  <= bus.req_wdata[2*RAM_W-1:RAM_W];
               if (misaligned(bus.req_size, bus.req_addr[2:0])) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
                  bus.resp_rdata <= '0;
                  state          <= ST_RESP;
               end else begin
                  ram_addr <= bus.req_addr[AWIDTH+1:2];
                  ram_we   <= bus.req_we ? st_be : 4'h0;
                  ram_di   <= st_di;
                  state    <= ST_ACC0;
               end
            end
            ST_ACC0: begin
               if (size_q == SIZE_D) begin
                  ram_addr <= ram_addr + AWIDTH'(1);  // wraps at top of RAM
                  ram_we   <= we_q ? 4'hF : 4'h0;
                  ram_di   <= whi_q;
                  state    <= ST_ACC1;
               end else if (we_q) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_rdata <= '0;
                  state          <= ST_RESP;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_ACC1: begin
               if (we_q) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_rdata <= '0;
                  state          <= ST_RESP;
               end else begin
                  lo_q  <= ram_do;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               bus.resp_valid <= 1'b1;
               bus.resp_rdata <= ld_data;
               state          <= ST_RESP;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
//   Scoreboard bench: the driver pushes expected responses computed from a
//   byte-addressed shadow memory; a monitor pops and compares on resp_valid.
//   RAM contents are compared against the shadow at the end.
module tb_ram_access_ctrl;
   import ram_access_ctrl_pkg::*;

   localparam int AW = 12;
   localparam int N  = 1 << AW;
   localparam int NB = 4 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_we;
   logic [31:0]   ram_di;
   logic [31:0]   ram_do;

   always #5 clk = ~clk;

   ram_access_ctrl_if #(.AWIDTH(AW), .XLEN(64)) bus ();

   ram_access_ctrl #(.AWIDTH(AW), .XLEN(64)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_di   (ram_di),
      .ram_do   (ram_do)
   );

   // Registered-read, byte-write-enable RAM.
   bit [31:0] mem [N];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_di[8*i +: 8];
      ram_do <= mem[ram_addr];
   end

   bit [7:0] sh [NB];   // reference memory, one entry per byte

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          err;
      bit          ld;
      logic [63:0] rd;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sbq [$];

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.resp_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp got=resp_valid exp=no_response");
         end else begin
            e = sbq.pop_front();
            chk("resp_err", 64'(bus.resp_err), 64'(e.err));
            chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
            if (e.err || e.ld) chk("resp_rdata", bus.resp_rdata, e.rd);
         end
      end
   end

   function automatic bit mis(size_e s, logic [13:0] a);
      int n = 1 << int'(s);
      return (int'(a) % n) != 0;
   endfunction

   // Issue one request; returns at the negedge of the cycle after accept.
   // track=0: the access will be aborted, so no response and no memory effect.
   task automatic issue(bit we, size_e sz, bit uns, logic [13:0] a,
                        logic [63:0] wd, bit track);
      exp_t        e;
      int          n;
      int          w;
      logic [63:0] v;
      w = 0;
      while (!bus.req_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) begin
         checks++;
         fails++;
         $display("FAIL req_ready_timeout got=0 exp=1");
         return;
      end
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      bus.req_valid    = 1'b1;
      n     = 1 << int'(sz);
      e.err = mis(sz, a);
      e.ld  = !we;
      e.rd  = '0;
      e.acc = cyc;
      if (e.err)   e.lat = 1;
      else if (we) e.lat = (sz == SIZE_D) ? 3 : 2;
      else         e.lat = (sz == SIZE_D) ? 4 : 3;
      if (!e.err && track) begin
         if (we) begin
            for (int i = 0; i < n; i++) sh[(int'(a) + i) % NB] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = sh[(int'(a) + i) % NB];
            if (!uns && sz != SIZE_D && v[8*n-1])
               v = v | ~((64'd1 << (8*n)) - 64'd1);
            e.rd = v;
         end
      end
      if (track) sbq.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   initial begin
      int          bad;
      int          w;
      bit          we;
      size_e       sz;
      logic [13:0] a;
      logic [63:0] wd;

      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = SIZE_B;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
      chk("rst_ram_we", 64'(ram_we), 64'd0);
      chk("rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("rst_ram_di", 64'(ram_di), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Store byte: check first RAM cycle, then hold req_valid while busy.
      issue(1'b1, SIZE_B, 1'b0, 14'h0006, 64'hA5, 1'b1);
      chk("sb_ram_addr", 64'(ram_addr), 64'd1);
      chk("sb_ram_we", 64'(ram_we), 64'h4);
      chk("sb_ram_di", 64'(ram_di), 64'hA5A5A5A5);
      bus.req_we    = 1'b1;
      bus.req_size  = SIZE_W;
      bus.req_addr  = 14'h0100;
      bus.req_wdata = 64'hDEADBEEF;
      bus.req_valid = 1'b1;
      repeat (2) @(negedge clk);
      bus.req_valid = 1'b0;

      issue(1'b1, SIZE_D, 1'b0, 14'h0010, 64'h1122334455667788, 1'b1);
      issue(1'b0, SIZE_D, 1'b0, 14'h0010, 64'h0, 1'b1);

      issue(1'b1, SIZE_W, 1'b0, 14'h0040, 64'h8000F0FF, 1'b1);
      issue(1'b0, SIZE_B, 1'b0, 14'h0040, 64'h0, 1'b1);
      issue(1'b0, SIZE_B, 1'b1, 14'h0040, 64'h0, 1'b1);
      issue(1'b0, SIZE_H, 1'b0, 14'h0042, 64'h0, 1'b1);
      issue(1'b0, SIZE_H, 1'b1, 14'h0042, 64'h0, 1'b1);
      issue(1'b0, SIZE_W, 1'b0, 14'h0040, 64'h0, 1'b1);
      issue(1'b0, SIZE_W, 1'b1, 14'h0040, 64'h0, 1'b1);

      issue(1'b0, SIZE_W, 1'b0, 14'h0002, 64'h0, 1'b1);
      issue(1'b1, SIZE_D, 1'b0, 14'h0004, 64'hFFFFFFFFFFFFFFFF, 1'b1);

      // Top of RAM: last aligned doubleword, and the odd last word (misaligned).
      issue(1'b1, SIZE_D, 1'b0, 14'h3FF8, 64'hCAFEF00D12345678, 1'b1);
      issue(1'b0, SIZE_D, 1'b0, 14'h3FF8, 64'h0, 1'b1);
      issue(1'b1, SIZE_D, 1'b0, 14'h3FFC, 64'h0123456789ABCDEF, 1'b1);

      // Reset during the first cycle of a doubleword store.
      issue(1'b1, SIZE_D, 1'b0, 14'h0020, 64'h0BADC0DE0BADC0DE, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
      issue(1'b0, SIZE_D, 1'b0, 14'h0020, 64'h0, 1'b1);

      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         sz = size_e'($urandom_range(0, 3));
         a  = 14'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a = a | 14'h3F00;
         if ($urandom_range(0, 3) != 0) a = a & ~14'((1 << int'(sz)) - 1);
         wd = {$urandom, $urandom};
         issue(we, sz, 1'($urandom_range(0, 1)), a, wd, 1'b1);
      end

      w = 0;
      while ((sbq.size() != 0 || !bus.req_ready) && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("drain_outstanding", 64'(sbq.size()), 64'd0);

      bad = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] != {sh[4*i+3], sh[4*i+2], sh[4*i+1], sh[4*i]}) begin
            if (bad < 4)
               $display("ram word %0h holds %h, model %h", i, mem[i],
                        {sh[4*i+3], sh[4*i+2], sh[4*i+1], sh[4*i]});
            bad++;
         end
      chk("ram_words_differing", 64'(bad), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
